// File: rtl/shift_arbiter_ctrl.sv
// shift_arbiter_ctrl: round-robin sharing of an external 32-bit left/right shifter pair between two requesters.
// Latency: accept in IDLE, one EXEC cycle to capture the shifter output, result presented in RESP the cycle after.
// Backpressure: RESP holds (req_ready low for both) until the granted requester's resp_ready; SHIFT_ARITH_EN enables arithmetic right shifts.
module shift_arbiter_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*WIDTH-1:0]     req_data,
    input  logic [2*SHAMT_W-1:0]   req_shamt,
    input  logic [1:0]             req_dir,
    input  logic [1:0]             req_arith,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   busy,
    output logic [WIDTH-1:0]       sh_a,
    output logic [SHAMT_W-1:0]     sh_b,
    input  logic [WIDTH-1:0]       sh_resl,
    input  logic [WIDTH-1:0]       sh_resr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [SHAMT_W-1:0] shamt;
        logic               dir;
    } req_t;

    state_t           state;
    state_t           state_nxt;
    req_t             req_lane [2];
    req_t             req_win;
    logic             ptr;
    logic             gnt;
    logic             win;
    logic             dir_q;
    logic             accept;
    logic             resp_hs;
    logic [WIDTH-1:0] shift_res;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_lane[i].a     = req_data[i*WIDTH +: WIDTH];
            req_lane[i].shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
            req_lane[i].dir   = req_dir[i];
        end
    end

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        win = ptr;
        if (req_valid == 2'b01) begin
            win = 1'b0;
        end else if (req_valid == 2'b10) begin
            win = 1'b1;
        end
    end

    assign req_win = req_lane[win];
    assign accept  = (state == IDLE) && (|req_valid);
    assign resp_hs = (state == RESP) && resp_ready[gnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        busy       = (state != IDLE);
        if (accept) begin
            req_ready[win] = 1'b1;
        end
        if (state == RESP) begin
            resp_valid[gnt] = 1'b1;
        end
    end

`ifdef SHIFT_ARITH_EN
    logic             arith_q;
    logic [WIDTH-1:0] sign_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arith_q <= 1'b0;
        end else if (accept) begin
            arith_q <= req_arith[win];
        end
    end

    // The external right shifter is logical; sign bits are OR-ed in over the vacated top positions.
    assign sign_fill = ~({WIDTH{1'b1}} >> sh_b);

    always_comb begin
        shift_res = dir_q ? sh_resr : sh_resl;
        if (dir_q && arith_q && sh_a[WIDTH-1]) begin
            shift_res = sh_resr | sign_fill;
        end
    end
`else
    logic unused_arith;

    assign unused_arith = ^req_arith;
    assign shift_res    = dir_q ? sh_resr : sh_resl;
`endif

    // Operands stay on the shifter inputs after the response; only a new accept replaces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a      <= '0;
            sh_b      <= '0;
            dir_q     <= 1'b0;
            gnt       <= 1'b0;
            ptr       <= 1'b0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                sh_a  <= req_win.a;
                sh_b  <= req_win.shamt;
                dir_q <= req_win.dir;
                gnt   <= win;
            end
            if (state == EXEC) begin
                resp_data <= shift_res;
            end
            if (resp_hs) begin
                ptr <= ~gnt;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench for shift_arbiter_ctrl: vector table, shift sweep, mid-op reset and randomized traffic vs. a shift model.
// The external shifters are modelled here as plain << and >> on the DUT's sh_a/sh_b.
module tb_shift_arbiter_ctrl;
    localparam int W  = 32;
    localparam int SW = 5;
`ifdef SHIFT_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*W-1:0]  req_data = '0;
    logic [2*SW-1:0] req_shamt = '0;
    logic [1:0]      req_dir = '0;
    logic [1:0]      req_arith = '0;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready = '0;
    logic [W-1:0]    resp_data;
    logic            busy;
    logic [W-1:0]    sh_a;
    logic [SW-1:0]   sh_b;
    logic [W-1:0]    sh_resl;
    logic [W-1:0]    sh_resr;

    shift_arbiter_ctrl #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_dir    (req_dir),
        .req_arith  (req_arith),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .sh_a       (sh_a),
        .sh_b       (sh_b),
        .sh_resl    (sh_resl),
        .sh_resr    (sh_resr)
    );

    assign sh_resl = sh_a << sh_b;
    assign sh_resr = sh_a >> sh_b;

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [1:0]  dir;
        logic [1:0]  arith;
        int          stall;
        int          gnt;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];
    int   checks = 0;
    int   failures = 0;
    logic ptr_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic dir, input logic arith);
        if (!dir) return a << s;
        if (arith && ARITH) return $signed(a) >>> s;
        return a >> s;
    endfunction

    // Called just after a falling edge; returns just after a falling edge with the DUT back in IDLE.
    task automatic run_op(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] dir,
                          input logic [1:0] arith, input int stall, input int gnt, input logic [31:0] exp);
        logic [1:0] oh;
        oh = (gnt == 1) ? 2'b10 : 2'b01;
        req_valid = vld;
        req_data  = {a1, a0};
        req_shamt = {s1, s0};
        req_dir   = dir;
        req_arith = arith;
        #1;
        check("idle_req_ready", {30'd0, req_ready}, {30'd0, oh});
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("exec_req_ready", {30'd0, req_ready}, 32'd0);
        check("exec_sh_a", sh_a, (gnt == 1) ? a1 : a0);
        check("exec_sh_b", {27'd0, sh_b}, {27'd0, (gnt == 1) ? s1 : s0});
        @(posedge clk);
        @(negedge clk);
        check("resp_valid", {30'd0, resp_valid}, {30'd0, oh});
        check("resp_data", resp_data, exp);
        check("resp_req_ready", {30'd0, req_ready}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            resp_ready = ~oh;
            @(posedge clk);
            @(negedge clk);
            check("stall_resp_valid", {30'd0, resp_valid}, {30'd0, oh});
            check("stall_resp_data", resp_data, exp);
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
            check("stall_busy", {31'd0, busy}, 32'd1);
        end
        resp_ready = oh;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 2'b00;
        req_valid  = 2'b00;
        check("post_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_resp_data_hold", resp_data, exp);
        ptr_m = (gnt == 0);
    endtask

    initial begin
        logic [31:0] exp_ar;
        exp_ar = ARITH ? 32'hFFFF_FFFF : 32'h0000_0001;
        tbl[0]  = '{2'b11, 32'h0000_0001, 32'h8000_0000, 5'd3,  5'd3,  2'b10, 2'b00, 0, 0, 32'h0000_0008};
        tbl[1]  = '{2'b11, 32'h0000_0001, 32'h8000_0000, 5'd3,  5'd3,  2'b10, 2'b00, 0, 1, 32'h1000_0000};
        tbl[2]  = '{2'b11, 32'h0000_0001, 32'h8000_0000, 5'd3,  5'd3,  2'b10, 2'b00, 0, 0, 32'h0000_0008};
        tbl[3]  = '{2'b11, 32'h0000_0001, 32'h8000_0000, 5'd3,  5'd3,  2'b10, 2'b00, 0, 1, 32'h1000_0000};
        tbl[4]  = '{2'b01, 32'h5555_5555, 32'h0000_0000, 5'd1,  5'd0,  2'b00, 2'b00, 0, 0, 32'hAAAA_AAAA};
        tbl[5]  = '{2'b10, 32'h0000_0000, 32'hAAAA_AAAA, 5'd0,  5'd4,  2'b10, 2'b00, 0, 1, 32'h0AAA_AAAA};
        tbl[6]  = '{2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd8,  5'd2,  2'b00, 2'b00, 5, 0, 32'hADBE_EF00};
        tbl[7]  = '{2'b10, 32'h0000_0000, 32'h8000_0000, 5'd0,  5'd31, 2'b10, 2'b10, 0, 1, exp_ar};
        tbl[8]  = '{2'b01, 32'hCAFE_F00D, 32'h0000_0000, 5'd0,  5'd0,  2'b01, 2'b00, 0, 0, 32'hCAFE_F00D};
        tbl[9]  = '{2'b11, 32'h0000_00FF, 32'h0000_0003, 5'd1,  5'd31, 2'b00, 2'b00, 0, 1, 32'h8000_0000};
        tbl[10] = '{2'b01, 32'h8000_0001, 32'h0000_0000, 5'd4,  5'd0,  2'b00, 2'b01, 0, 0, 32'h0000_0010};
        tbl[11] = '{2'b10, 32'h0000_0000, 32'h4000_0000, 5'd0,  5'd30, 2'b10, 2'b10, 0, 1, 32'h0000_0001};

        #2;
        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sh_a", sh_a, 32'd0);
        check("rst_sh_b", {27'd0, sh_b}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        #10;
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_op(tbl[i].vld, tbl[i].a0, tbl[i].a1, tbl[i].s0, tbl[i].s1, tbl[i].dir,
                   tbl[i].arith, tbl[i].stall, tbl[i].gnt, tbl[i].exp);
        end

        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 32; s++) begin
                run_op(2'b01, 32'h5555_5555, 32'h0, 5'(s), 5'd0, {1'b0, 1'(d)}, 2'b00, 0, 0,
                       model(32'h5555_5555, s, 1'(d), 1'b0));
            end
        end

        // Reset in EXEC: everything clears at once and no stale response follows.
        req_valid = 2'b01;
        req_data  = {32'h0, 32'h1234_5678};
        req_shamt = {5'd0, 5'd4};
        req_dir   = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_sh_a", sh_a, 32'd0);
        check("mid_rst_resp_data", resp_data, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_no_stale_resp", {30'd0, resp_valid}, 32'd0);
            check("mid_idle_busy", {31'd0, busy}, 32'd0);
        end
        ptr_m = 1'b0;
        run_op(2'b11, 32'h0000_0001, 32'h8000_0000, 5'd3, 5'd3, 2'b10, 2'b00, 0, 0, 32'h0000_0008);

        for (int n = 0; n < 200; n++) begin
            logic [1:0]  vld;
            logic [31:0] a0, a1;
            logic [4:0]  s0, s1;
            logic [1:0]  dir, arith;
            int          g;
            if ($urandom_range(0, 4) == 0) begin
                vld = 2'($urandom_range(1, 3));
                g = (vld == 2'b11) ? int'(ptr_m) : ((vld == 2'b01) ? 0 : 1);
                req_valid = vld;
                #1;
                check("drop_req_ready", {30'd0, req_ready}, (g == 1) ? 32'd2 : 32'd1);
                #1;
                req_valid = 2'b00;
                @(posedge clk);
                @(negedge clk);
                check("drop_not_accepted", {31'd0, busy}, 32'd0);
            end
            vld   = 2'($urandom_range(1, 3));
            a0    = $urandom;
            a1    = $urandom;
            s0    = 5'($urandom);
            s1    = 5'($urandom);
            dir   = 2'($urandom);
            arith = 2'($urandom);
            g = (vld == 2'b11) ? int'(ptr_m) : ((vld == 2'b01) ? 0 : 1);
            if (g == 1) begin
                run_op(vld, a0, a1, s0, s1, dir, arith, $urandom_range(0, 3), g,
                       model(a1, int'(s1), dir[1], arith[1]));
            end else begin
                run_op(vld, a0, a1, s0, s1, dir, arith, $urandom_range(0, 3), g,
                       model(a0, int'(s0), dir[0], arith[0]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
